mmac_loader: RTL

MMAC_LOADER -- requirements
Module: mmac_loader

---
 rtl/mmac_pkg.sv | 20 ++
 rtl/mmac_elem_buf.sv | 33 +++
 rtl/mmac_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/mmac_pkg.sv
// Shared types and constants for the matrix MAC operand loader.
// Element geometry defaults live here so the loader and its buffers agree on sizes.
package mmac_pkg;

  localparam int VAR_WIDTH = 8;
  localparam int M_SIZE    = 4;
  localparam int ELEM_CNT  = M_SIZE * M_SIZE;
  localparam int CNT_WIDTH = $clog2(ELEM_CNT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ISSUE,
    WAIT
  } loader_state_t;

  typedef logic [VAR_WIDTH-1:0] elem_t;

endpackage

// File: rtl/mmac_elem_buf.sv
// One matrix worth of element registers with a single indexed write port.
// The whole array is presented as a flat row-major vector, element k at [k*VAR_WIDTH +: VAR_WIDTH].
module mmac_elem_buf
  import mmac_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [CNT_WIDTH-1:0]          wr_idx,
  input  elem_t                         wr_data,
  output logic [ELEM_CNT*VAR_WIDTH-1:0] flat
);

  elem_t mem [ELEM_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ELEM_CNT; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < ELEM_CNT; i++) begin
      flat[i*VAR_WIDTH +: VAR_WIDTH] = mem[i];
    end
  end

endmodule

// File: rtl/mmac_loader.sv
// Streams 2*M_SIZE*M_SIZE elements into operand matrices A then B, pulses mac_start,
// and holds the operands stable until the MAC reports done.
//
// Handshake: an element transfers on a rising edge where in_valid && in_ready are both
// high; in_ready depends only on state (never on in_valid), and flush drops that element.
module mmac_loader #(
  parameter int VAR_WIDTH = mmac_pkg::VAR_WIDTH,
  parameter int M_SIZE    = mmac_pkg::M_SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [VAR_WIDTH-1:0]              in_data,
  output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0] mat_a,
  output logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0] mat_b,
  output logic                              mac_start,
  input  logic                              mac_done,
  output logic                              busy,
  output mmac_pkg::loader_state_t           dbg_state
);

  import mmac_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(ELEM_CNT - 1);

  loader_state_t        state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 wr_a, wr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // flush overrides everything, including a same-cycle transfer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    if (flush) begin
      state_nxt = LOAD_A;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: state_nxt = LOAD_A;
        LOAD_A: begin
          if (in_valid) begin
            wr_a    = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state_nxt = LOAD_B;
              cnt_nxt   = '0;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            wr_b    = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state_nxt = ISSUE;
              cnt_nxt   = '0;
            end
          end
        end
        ISSUE: state_nxt = WAIT;
        WAIT: begin
          if (mac_done) begin
            state_nxt = LOAD_A;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign mac_start = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign dbg_state = state;

  mmac_elem_buf u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_a),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .flat    (mat_a)
  );

  mmac_elem_buf u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_b),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .flat    (mat_b)
  );

endmodule
